// File: rtl/rtu_rsp_buffer.sv
// rtu_rsp_buffer: demultiplexes the shared RTU response bus into one
// first-word-fall-through FIFO per ingress port. The head of each FIFO is
// presented to the switch core as a parallel valid/ack interface.
//
// Handshake: rtu_rsp_valid_o[p] is high whenever FIFO p holds at least one
// entry, and the head fields of port p are stable while it stays high. An
// entry is consumed at a rising edge where both rtu_rsp_valid_o[p] and
// rtu_rsp_ack_i[p] are high. An ack while valid is low has no effect. The
// input side has no backpressure: a response aimed at a full port is dropped
// and recorded in the sticky overflow_o flag.
module rtu_rsp_buffer #(
    parameter int g_num_ports      = 11,
    parameter int g_port_idx_width = 4,
    parameter int g_prio_width     = 3,
    parameter int g_fifo_depth     = 4
) (
    input  logic                                 clk_i,
    input  logic                                 rst_n_i,
    input  logic                                 rsp_valid_i,
    input  logic [g_port_idx_width-1:0]          rsp_port_i,
    input  logic [g_num_ports-1:0]               rsp_mask_i,
    input  logic                                 rsp_drop_i,
    input  logic [g_prio_width-1:0]              rsp_prio_i,
    output logic [g_num_ports-1:0]               rsp_full_o,
    output logic [g_num_ports-1:0]               rtu_rsp_valid_o,
    input  logic [g_num_ports-1:0]               rtu_rsp_ack_i,
    output logic [g_num_ports*g_num_ports-1:0]   rtu_dst_port_mask_o,
    output logic [g_num_ports-1:0]               rtu_drop_o,
    output logic [g_num_ports*g_prio_width-1:0]  rtu_prio_o,
    output logic [g_num_ports-1:0]               overflow_o,
    output logic                                 bad_port_o
);

    localparam int PtrW = $clog2(g_fifo_depth);
    localparam int CntW = PtrW + 1;
    localparam int EntW = g_num_ports + 1 + g_prio_width;

    // Entry layout: {mask, drop, prio}
    typedef logic [EntW-1:0] entry_t;

    entry_t          mem_q    [g_num_ports][g_fifo_depth];
    entry_t          mem_d    [g_num_ports][g_fifo_depth];
    logic [PtrW-1:0] rd_ptr_q [g_num_ports];
    logic [PtrW-1:0] rd_ptr_d [g_num_ports];
    logic [PtrW-1:0] wr_ptr_q [g_num_ports];
    logic [PtrW-1:0] wr_ptr_d [g_num_ports];
    logic [CntW-1:0] cnt_q    [g_num_ports];
    logic [CntW-1:0] cnt_d    [g_num_ports];

    logic [g_num_ports-1:0] overflow_q, overflow_d;
    logic                   bad_port_q, bad_port_d;

    logic                   in_range;
    logic [g_num_ports-1:0] sel;
    logic [g_num_ports-1:0] full;
    logic [g_num_ports-1:0] valid;
    logic [g_num_ports-1:0] push;
    logic [g_num_ports-1:0] pop;
    entry_t                 wr_entry;

    assign in_range = 32'(rsp_port_i) < 32'(g_num_ports);
    assign wr_entry = {rsp_mask_i, rsp_drop_i, rsp_prio_i};

    // Per-port status from the registered counts; fullness is judged on the
    // pre-clock count, so a same-cycle pop never makes room for a push.
    always_comb begin
        sel = '0;
        if (rsp_valid_i && in_range) begin
            sel[rsp_port_i] = 1'b1;
        end
        for (int p = 0; p < g_num_ports; p++) begin
            full[p]  = (cnt_q[p] == CntW'(g_fifo_depth));
            valid[p] = (cnt_q[p] != '0);
        end
        push = sel & ~full;
        pop  = rtu_rsp_ack_i & valid;
    end

    // Next-state for storage, pointers, counts and the status flags.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        for (int p = 0; p < g_num_ports; p++) begin
            if (push[p]) begin
                mem_d[p][wr_ptr_q[p]] = wr_entry;
                wr_ptr_d[p]           = wr_ptr_q[p] + PtrW'(1);
            end
            if (pop[p]) begin
                rd_ptr_d[p] = rd_ptr_q[p] + PtrW'(1);
            end
            case ({push[p], pop[p]})
                2'b10:   cnt_d[p] = cnt_q[p] + CntW'(1);
                2'b01:   cnt_d[p] = cnt_q[p] - CntW'(1);
                default: cnt_d[p] = cnt_q[p];
            endcase
        end
        overflow_d = overflow_q | (sel & full);
        bad_port_d = rsp_valid_i && !in_range;
    end

    // Head fields come straight from the entry at each read pointer.
    always_comb begin
        for (int p = 0; p < g_num_ports; p++) begin
            {rtu_dst_port_mask_o[p*g_num_ports +: g_num_ports],
             rtu_drop_o[p],
             rtu_prio_o[p*g_prio_width +: g_prio_width]} = mem_q[p][rd_ptr_q[p]];
        end
    end

    assign rsp_full_o      = full;
    assign rtu_rsp_valid_o = valid;
    assign overflow_o      = overflow_q;
    assign bad_port_o      = bad_port_q;

    // State registers; reset zeroes the storage too so heads never carry X.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int p = 0; p < g_num_ports; p++) begin
                for (int e = 0; e < g_fifo_depth; e++) begin
                    mem_q[p][e] <= '0;
                end
                rd_ptr_q[p] <= '0;
                wr_ptr_q[p] <= '0;
                cnt_q[p]    <= '0;
            end
            overflow_q <= '0;
            bad_port_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            bad_port_q <= bad_port_d;
        end
    end

endmodule

// File: tb/tb_rtu_rsp_buffer.sv
// tb_rtu_rsp_buffer: directed and randomized stimulus for rtu_rsp_buffer,
// checked against per-port reference queues.
module tb_rtu_rsp_buffer;

    localparam int NP    = 11;
    localparam int PIW   = 4;
    localparam int PW    = 3;
    localparam int DEPTH = 4;
    localparam int EW    = NP + 1 + PW;

    logic                clk = 1'b0;
    logic                rst_n_i;
    logic                rsp_valid_i;
    logic [PIW-1:0]      rsp_port_i;
    logic [NP-1:0]       rsp_mask_i;
    logic                rsp_drop_i;
    logic [PW-1:0]       rsp_prio_i;
    logic [NP-1:0]       rsp_full_o;
    logic [NP-1:0]       rtu_rsp_valid_o;
    logic [NP-1:0]       rtu_rsp_ack_i;
    logic [NP*NP-1:0]    rtu_dst_port_mask_o;
    logic [NP-1:0]       rtu_drop_o;
    logic [NP*PW-1:0]    rtu_prio_o;
    logic [NP-1:0]       overflow_o;
    logic                bad_port_o;

    // Reference model state
    logic [EW-1:0] exp_q [NP][$];
    logic [NP-1:0] exp_ovf;
    logic          exp_bad;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    rtu_rsp_buffer #(
        .g_num_ports      (NP),
        .g_port_idx_width (PIW),
        .g_prio_width     (PW),
        .g_fifo_depth     (DEPTH)
    ) dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n_i),
        .rsp_valid_i         (rsp_valid_i),
        .rsp_port_i          (rsp_port_i),
        .rsp_mask_i          (rsp_mask_i),
        .rsp_drop_i          (rsp_drop_i),
        .rsp_prio_i          (rsp_prio_i),
        .rsp_full_o          (rsp_full_o),
        .rtu_rsp_valid_o     (rtu_rsp_valid_o),
        .rtu_rsp_ack_i       (rtu_rsp_ack_i),
        .rtu_dst_port_mask_o (rtu_dst_port_mask_o),
        .rtu_drop_o          (rtu_drop_o),
        .rtu_prio_o          (rtu_prio_o),
        .overflow_o          (overflow_o),
        .bad_port_o          (bad_port_o)
    );

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] rand_ent();
        return EW'($urandom());
    endfunction

    // Reference model: one edge of behaviour, computed from queue sizes
    // before the edge.
    task automatic model_edge(input logic v, input int port, input logic [EW-1:0] ent,
                              input logic [NP-1:0] ack, input logic rst);
        logic [NP-1:0] pop_now;
        logic          push_now;
        if (rst) begin
            for (int p = 0; p < NP; p++) exp_q[p].delete();
            exp_ovf = '0;
            exp_bad = 1'b0;
            return;
        end
        push_now = 1'b0;
        for (int p = 0; p < NP; p++) pop_now[p] = ack[p] && (exp_q[p].size() > 0);
        exp_bad = v && (port >= NP);
        if (v && port < NP) begin
            if (exp_q[port].size() >= DEPTH) exp_ovf[port] = 1'b1;
            else                             push_now = 1'b1;
        end
        for (int p = 0; p < NP; p++) if (pop_now[p]) void'(exp_q[p].pop_front());
        if (push_now) exp_q[port].push_back(ent);
    endtask

    task automatic compare_all();
        logic [NP-1:0]    ev, ef, ed, od;
        logic [NP*NP-1:0] em, om;
        logic [NP*PW-1:0] ep, op;
        ev = '0; ef = '0; ed = '0; od = '0; em = '0; om = '0; ep = '0; op = '0;
        for (int p = 0; p < NP; p++) begin
            ev[p] = exp_q[p].size() > 0;
            ef[p] = exp_q[p].size() == DEPTH;
            if (ev[p]) begin
                {em[p*NP +: NP], ed[p], ep[p*PW +: PW]} = exp_q[p][0];
                om[p*NP +: NP] = rtu_dst_port_mask_o[p*NP +: NP];
                od[p]          = rtu_drop_o[p];
                op[p*PW +: PW] = rtu_prio_o[p*PW +: PW];
            end
        end
        check_eq("valid",    128'(rtu_rsp_valid_o), 128'(ev));
        check_eq("full",     128'(rsp_full_o),      128'(ef));
        check_eq("overflow", 128'(overflow_o),      128'(exp_ovf));
        check_eq("bad_port", 128'(bad_port_o),      128'(exp_bad));
        check_eq("head_mask", 128'(om), 128'(em));
        check_eq("head_drop", 128'(od), 128'(ed));
        check_eq("head_prio", 128'(op), 128'(ep));
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic v, input int port, input logic [EW-1:0] ent,
                        input logic [NP-1:0] ack, input logic rst);
        rst_n_i       = !rst;
        rsp_valid_i   = v;
        rsp_port_i    = port[PIW-1:0];
        {rsp_mask_i, rsp_drop_i, rsp_prio_i} = ent;
        rtu_rsp_ack_i = ack;
        @(posedge clk);
        model_edge(v, port, ent, ack, rst);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, '0, '0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 0, '0, '1, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [EW-1:0] e;
        int rr;
        logic v;
        rst_n_i = 1'b0; rsp_valid_i = 1'b0; rsp_port_i = '0;
        rsp_mask_i = '0; rsp_drop_i = 1'b0; rsp_prio_i = '0; rtu_rsp_ack_i = '0;
        exp_ovf = '0; exp_bad = 1'b0;

        // Reset with garbage on the bus: everything must come up zero.
        step(1'b1, 2, rand_ent(), '1, 1'b1);
        step(1'b0, 0, '0, '0, 1'b1);
        check_eq("rst_valid", 128'(rtu_rsp_valid_o), 128'(0));
        check_eq("rst_mask",  128'(rtu_dst_port_mask_o), 128'(0));
        check_eq("rst_drop",  128'(rtu_drop_o), 128'(0));
        check_eq("rst_prio",  128'(rtu_prio_o), 128'(0));
        check_eq("rst_ovf",   128'(overflow_o), 128'(0));

        // Single push to port 3 after some idle cycles.
        idle(8);
        step(1'b1, 3, {11'h005, 1'b0, 3'd5}, '0, 1'b0);
        check_eq("p3_valid", 128'(rtu_rsp_valid_o), 128'(1 << 3));
        check_eq("p3_mask",  128'(rtu_dst_port_mask_o[3*NP +: NP]), 128'(11'h005));
        check_eq("p3_prio",  128'(rtu_prio_o[3*PW +: PW]), 128'(3'd5));
        step(1'b0, 0, '0, NP'(1 << 3), 1'b0);

        // Fill port 0, overflow it, then drain in order.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 0, rand_ent(), '0, 1'b0);
        check_eq("p0_full", 128'(rsp_full_o[0]), 128'(1));
        step(1'b1, 0, rand_ent(), '0, 1'b0);
        check_eq("p0_ovf", 128'(overflow_o[0]), 128'(1));
        for (int i = 0; i < DEPTH; i++) step(1'b0, 0, '0, NP'(1), 1'b0);
        check_eq("p0_empty", 128'(rtu_rsp_valid_o[0]), 128'(0));

        // Port 1 full with push+ack together: push rejected, one pop.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1, rand_ent(), '0, 1'b0);
        step(1'b1, 1, rand_ent(), NP'(1 << 1), 1'b0);
        check_eq("p1_ovf",  128'(overflow_o[1]), 128'(1));
        check_eq("p1_full", 128'(rsp_full_o[1]), 128'(0));
        // Port 2 at count 2 with push+ack: count stays, order kept.
        step(1'b1, 2, rand_ent(), '0, 1'b0);
        step(1'b1, 2, rand_ent(), '0, 1'b0);
        step(1'b1, 2, rand_ent(), NP'(1 << 2), 1'b0);
        drain();

        // Out-of-range port: nothing stored, single-cycle bad_port pulse.
        step(1'b1, 12, rand_ent(), '0, 1'b0);
        check_eq("bad_pulse", 128'(bad_port_o), 128'(1));
        check_eq("bad_novalid", 128'(rtu_rsp_valid_o), 128'(0));
        step(1'b0, 0, '0, '0, 1'b0);
        check_eq("bad_clear", 128'(bad_port_o), 128'(0));
        step(1'b1, 15, rand_ent(), '0, 1'b0);
        step(1'b1, 11, rand_ent(), '0, 1'b0);
        idle(1);

        // Random round-robin traffic with random acks, pushes kept off full ports.
        step(1'b0, 0, '0, '0, 1'b1);
        for (int c = 0; c < 2000; c++) begin
            rr = c % NP;
            v  = ($urandom_range(0, 9) != 0) && (exp_q[rr].size() < DEPTH);
            step(v, rr, rand_ent(), NP'($urandom()), 1'b0);
        end
        check_eq("rand_no_ovf", 128'(overflow_o), 128'(0));
        drain();

        // Reset with entries queued in port 5, then a lone push.
        for (int i = 0; i < 3; i++) step(1'b1, 5, rand_ent(), '0, 1'b0);
        step(1'b1, 5, rand_ent(), '0, 1'b1);
        check_eq("mid_rst_valid", 128'(rtu_rsp_valid_o), 128'(0));
        e = {11'h7a1, 1'b1, 3'd2};
        step(1'b1, 5, e, '0, 1'b0);
        check_eq("post_rst_valid", 128'(rtu_rsp_valid_o), 128'(1 << 5));
        check_eq("post_rst_drop",  128'(rtu_drop_o[5]), 128'(1));
        step(1'b0, 0, '0, NP'(1 << 5), 1'b0);
        check_eq("post_rst_empty", 128'(rtu_rsp_valid_o), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        n_fail++;
        $display("[TB] FAIL timeout: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
